// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// ---------------
// Elastic pipeline register with a one-entry skid buffer. It sits between two
// pipeline stages and passes a packed payload across a valid/ready handshake.
// Because of the skid register, in_ready depends only on local state. The
// downstream out_ready therefore never ripples combinationally back upstream.
// A synchronous flush empties the stage and parks the BUBBLE payload on
// out_data. The same happens on reset.
//
// Parameters:
//   DATA_W     payload width in bits (>= 1)
//   BUBBLE     payload presented on out_data whenever the stage is empty
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream offers in_data this cycle
//   in_ready   stage can take an entry (decoded from state only)
//   in_data    upstream payload
//   flush      synchronous kill of every held entry
//   out_valid  out_data holds a valid entry
//   out_ready  downstream consumes when high together with out_valid
//   out_data   head payload (main register)
//   occupancy  number of held entries: 0, 1 or 2

module pipe_stage_skid #(
    parameter int unsigned          DATA_W = 32,
    parameter logic [DATA_W-1:0]    BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // The encoding equals the entry count, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    logic w_accept;
    logic w_fire;

    // Every output is a pure decode of flops. The handshake terms below only
    // feed the next-state logic and never reach an output combinationally.
    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign occupancy = r_state;
    assign out_data  = r_main;

    assign w_accept = in_valid & in_ready;
    assign w_fire   = out_valid & out_ready;

    // State and storage update.
    // Flush behaves exactly like reset. An entry offered in the same cycle is
    // dropped. A fire in the same cycle has already been taken downstream.
    // The skid register is loaded only when the main register is stalled. It
    // drains into main as soon as the head is consumed. This keeps FIFO order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= EMPTY;
            r_main  <= BUBBLE;
            r_skid  <= BUBBLE;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state <= ONE;
                        r_main  <= in_data;
                    end
                end
                ONE: begin
                    if (w_accept && w_fire) begin
                        r_main <= in_data;
                    end else if (w_accept) begin
                        r_state <= FULL;
                        r_skid  <= in_data;
                    end else if (w_fire) begin
                        r_state <= EMPTY;
                        r_main  <= BUBBLE;
                    end
                end
                FULL: begin
                    if (w_fire) begin
                        r_state <= ONE;
                        r_main  <= r_skid;
                        r_skid  <= BUBBLE;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_main  <= BUBBLE;
                    r_skid  <= BUBBLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
// ------------------
// Scoreboard bench for pipe_stage_skid with DATA_W=32 and BUBBLE=32'h13.
// The stimulus side pushes each accepted payload into expQ. It empties the
// queue on flush or reset. A separate monitor pops the queue on every output
// handshake and compares out_data. The monitor also checks that occupancy,
// out_valid and in_ready agree with the number of outstanding entries. It
// checks that a stalled head stays put and that an empty stage shows BUBBLE.
// Directed steps also compare the outputs against hand-computed values.

module tb_pipe_stage_skid;

    localparam int unsigned       DW  = 32;
    localparam logic [DW-1:0]     BUB = 32'h00000013;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] expQ[$];

    logic          prevStall = 1'b0;
    logic [DW-1:0] prevData  = '0;

    pipe_stage_skid #(
        .DATA_W (DW),
        .BUBBLE (BUB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    // 10-time-unit clock. Rising edges fall at 5, 15, 25 and so on.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor. It runs on the falling edge, when the inputs for the coming
    // rising edge are stable. Only the monitor pops the scoreboard queue.
    always @(negedge clk) begin
        if (prevStall) begin
            checks++;
            if (!out_valid || out_data !== prevData) begin
                errors++;
                $display("[TB] FAIL stall_hold: got valid=%0b data=%h, required valid=1 data=%h",
                         out_valid, out_data, prevData);
            end
        end
        checks++;
        if (int'(occupancy) != expQ.size()) begin
            errors++;
            $display("[TB] FAIL occupancy_model: got %0d, required %0d", occupancy, expQ.size());
        end
        checks++;
        if (out_valid !== (expQ.size() != 0)) begin
            errors++;
            $display("[TB] FAIL valid_model: got %b, required %0b", out_valid, expQ.size() != 0);
        end
        checks++;
        if (in_ready !== (expQ.size() < 2)) begin
            errors++;
            $display("[TB] FAIL ready_model: got %b, required %0b", in_ready, expQ.size() < 2);
        end
        if (!out_valid) begin
            checks++;
            if (out_data !== BUB) begin
                errors++;
                $display("[TB] FAIL empty_bubble: got %h, required %h", out_data, BUB);
            end
        end else if (out_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL fire_data: got %h, required no output (queue empty)", out_data);
            end else begin
                logic [DW-1:0] exp;
                exp = expQ.pop_front();
                if (out_data !== exp) begin
                    errors++;
                    $display("[TB] FAIL fire_data: got %h, required %h", out_data, exp);
                end
            end
        end
        prevStall = out_valid && !out_ready && !flush && !rst;
        prevData  = out_data;
    end

    // Drives one cycle of inputs. The caller sits just after a rising edge.
    // The scoreboard is updated just after the falling edge, once the monitor
    // has popped. The task returns just after the next rising edge, so the
    // registered result of this cycle is visible on return.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                 input logic r, input logic f, input logic rs);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        rst       = rs;
        @(negedge clk);
        #1;
        if (rs || f)
            expQ.delete();
        else if (v && in_ready)
            expQ.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Compares the outputs against hand-computed values.
    task automatic checkOutput(input string name, input logic v, input logic [DW-1:0] d,
                               input logic [1:0] occ, input logic ir);
        checks++;
        if (out_valid !== v || out_data !== d || occupancy !== occ || in_ready !== ir) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%b data=%h occ=%0d ready=%b, required valid=%b data=%h occ=%0d ready=%b",
                     name, out_valid, out_data, occupancy, in_ready, v, d, occ, ir);
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset", 1'b0, BUB, 2'd0, 1'b1);

        // Streaming. Each entry appears one cycle after it is accepted.
        applyStimulus(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
        checkOutput("stream_11", 1'b1, 32'h11, 2'd1, 1'b1);
        applyStimulus(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
        checkOutput("stream_22", 1'b1, 32'h22, 2'd1, 1'b1);
        applyStimulus(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
        checkOutput("stream_33", 1'b1, 32'h33, 2'd1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("stream_drain", 1'b0, BUB, 2'd0, 1'b1);

        // Stall and skid. 0xC is offered while full and must be refused.
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        checkOutput("skid_one", 1'b1, 32'hA, 2'd1, 1'b1);
        applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        checkOutput("skid_full", 1'b1, 32'hA, 2'd2, 1'b0);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        checkOutput("skid_refuse", 1'b1, 32'hA, 2'd2, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("skid_pop_a", 1'b1, 32'hB, 2'd1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("skid_pop_b", 1'b0, BUB, 2'd0, 1'b1);

        // Flush while full, with 0xC offered in the same cycle.
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_pre", 1'b1, 32'hA, 2'd2, 1'b0);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_full", 1'b0, BUB, 2'd0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_no_c", 1'b0, BUB, 2'd0, 1'b1);

        // Reset while full with out_ready high, then 1-cycle latency again.
        applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h66, 1'b1, 1'b0, 1'b1);
        checkOutput("reset_mid", 1'b0, BUB, 2'd0, 1'b1);
        applyStimulus(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_latency", 1'b1, 32'h77, 2'd1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Accept and fire in the same cycle while holding one entry.
        applyStimulus(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
        checkOutput("af_hold5", 1'b1, 32'h5, 2'd1, 1'b1);
        applyStimulus(1'b1, 32'h6, 1'b1, 1'b0, 1'b0);
        checkOutput("af_swap6", 1'b1, 32'h6, 2'd1, 1'b1);

        // Flush in the same cycle that 0x6 fires. 0x6 still counts as delivered.
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_fire", 1'b0, BUB, 2'd0, 1'b1);

        // Random handshakes at 50%, including all-zero and all-one payloads.
        for (int i = 0; i < 2000; i++) begin
            logic [DW-1:0] d;
            d = (i % 97 == 0) ? '1 : ((i % 89 == 0) ? '0 : DW'($urandom));
            applyStimulus(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("random_drained", 1'b0, BUB, 2'd0, 1'b1);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got %0d entries left, required 0", expQ.size());
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
